i2c_register_target: RTL
========================

I2C_REGISTER_TARGET -- requirements
Module: i2c_register_target

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDRESS_WIDTH  7  device address bits
  REGISTER_WIDTH  8  register pointer bits
  DATA_WIDTH  8  data byte bits
REQ-002 Ports, one per line: name, direction, width, meaning (clock and reset first).
  clock  input  1  single system clock; all logic synchronous to it
  reset_n  input  1  asynchronous, active-low reset
  device_address  input  ADDRESS_WIDTH  own bus address, static while not busy
  external_serial_clock  input  1  SCL from bus; no clock stretching
  external_serial_data  inout  1  SDA, open-drain: drive 0 or high-Z, never drive 1
  register_address  output  REGISTER_WIDTH  current register pointer
  write_data  output  DATA_WIDTH  last received data byte
  write_valid  output  1  one-cycle strobe: write_data is valid for register_address
  read_request  output  1  one-cycle strobe: user presents read_data next cycle
  read_data  input  DATA_WIDTH  byte for register_address, sampled 1 cycle after read_request
  busy  output  1  high from addressed START until STOP or release

Function
REQ-003 SCL and SDA SHALL each pass through a 2-flop synchronizer plus 1 history flop; edges are detected on synchronized values (3-cycle detect latency).
REQ-004 START = synchronized SDA falls while SCL high; STOP = SDA rises while SCL high; both SHALL be recognised in every state.
REQ-005 Received bits SHALL be sampled on synchronized SCL rising edge, MSB first; SDA drive changes SHALL occur only on the cycle after a detected SCL falling edge.
REQ-006 States: IDLE, DEVICE_ADDRESS, ADDRESS_ACK, REGISTER_ADDRESS, REGISTER_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, IGNORE.
REQ-007 IDLE -> DEVICE_ADDRESS on START; 8-bit counter cleared.
REQ-008 After 8 bits in DEVICE_ADDRESS: address match -> ADDRESS_ACK (drive SDA low for the 9th clock, busy=1); mismatch -> IGNORE, SDA released.
REQ-009 ADDRESS_ACK exit on 9th SCL falling: R/W=0 and no pointer yet in this transaction -> REGISTER_ADDRESS; R/W=0 after pointer set -> WRITE_DATA; R/W=1 -> READ_DATA.
REQ-010 REGISTER_ADDRESS: 8 bits load register_address; REGISTER_ACK drives ACK; next -> WRITE_DATA.
REQ-011 WRITE_DATA: after 8th bit, write_data updated and write_valid pulses once (cycle after 8th rising edge); WRITE_ACK drives ACK; then register_address increments, -> WRITE_DATA.
REQ-012 READ_DATA entry: read_request pulses on entry; read_data captured into shift register next cycle, before first SCL falling edge; bits driven MSB first (0 = drive low, 1 = release).
REQ-013 READ_ACK: SDA released; master ACK (0) -> register_address increments, -> READ_DATA; master NACK (1) -> IGNORE.
REQ-014 Repeated START in any state SHALL go to DEVICE_ADDRESS with SDA released, register_address kept.
REQ-015 STOP in any state SHALL go to IDLE, release SDA, clear busy; register_address kept.
REQ-016 register_address increment SHALL wrap modulo 2^REGISTER_WIDTH (0xFF -> 0x00).
REQ-017 IGNORE: SDA released, no strobes; leaves only on START or STOP.
REQ-018 Required SCL high and low phases: at least 6 clock cycles each.

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE, SDA high-Z, busy=0, write_valid=0, read_request=0, register_address=0, write_data=0, shift register and bit counter=0.
REQ-020 Reset asserted mid-transfer SHALL release SDA in the same cycle; after release, the block waits for a new START.

Verification
REQ-021 device_address=0x11; write 0x11+W, reg 0x05, data 0xA5, STOP -> three ACKs; single write_valid with register_address=0x05, write_data=0xA5; busy low after STOP.
REQ-022 Write 0x11+W, reg 0x05, repeated START, 0x11+R, read_data=0x3C, master NACK, STOP -> read_request once; bits 0x3C on SDA; IDLE after STOP.
REQ-023 Address 0x22+W -> no ACK (SDA high on 9th clock), no strobes, busy stays 0 until STOP.
REQ-024 Write burst reg 0xFE, data 0x01,0x02,0x03 -> write_valid at addresses 0xFE, 0xFF, 0x00.
REQ-025 reset_n low during ADDRESS_ACK (SDA driven low) -> SDA released immediately, all outputs at reset values; next full write completes normally.
REQ-026 STOP injected mid-byte in WRITE_DATA -> no write_valid, return to IDLE, SDA released.

Source files
------------

// File: rtl/i2c_register_target.sv
// I2C register-access target: synchronized SCL/SDA front end, byte-level FSM,
// auto-incrementing register pointer, open-drain SDA with ACK and read-data drive.
module i2c_register_target #(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int REGISTER_WIDTH = 8,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDRESS_WIDTH-1:0]  device_address,
  input  logic                      external_serial_clock,
  inout  wire                       external_serial_data,
  output logic [REGISTER_WIDTH-1:0] register_address,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      write_valid,
  output logic                      read_request,
  input  logic [DATA_WIDTH-1:0]     read_data,
  output logic                      busy
);

  // state            | meaning
  // IDLE             | bus free, waiting for START
  // DEVICE_ADDRESS   | shifting in 7-bit address + R/W
  // ADDRESS_ACK      | driving ACK for our address
  // REGISTER_ADDRESS | shifting in register pointer
  // REGISTER_ACK     | driving ACK for pointer byte
  // WRITE_DATA       | shifting in a data byte
  // WRITE_ACK        | driving ACK for data byte, then pointer++
  // READ_DATA        | shifting out read_data MSB first
  // READ_ACK         | sampling master ACK/NACK
  // IGNORE           | not addressed or master NACK; wait for START/STOP
  typedef enum logic [3:0] {
    IDLE, DEVICE_ADDRESS, ADDRESS_ACK, REGISTER_ADDRESS, REGISTER_ACK,
    WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, IGNORE
  } state_t;

  localparam int AW1 = ADDRESS_WIDTH + 1;
  localparam int SW0 = (AW1 > REGISTER_WIDTH) ? AW1 : REGISTER_WIDTH;
  localparam int SW  = (SW0 > DATA_WIDTH) ? SW0 : DATA_WIDTH;
  localparam int CW  = (SW > 2) ? $clog2(SW) : 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH);
  localparam logic [CW-1:0] REG_LAST  = CW'(REGISTER_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  logic [2:0] scl_pipe, sda_pipe;
  logic       scl_sync, scl_hist, sda_sync, sda_hist;
  logic       scl_rise, scl_fall, start_seen, stop_seen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], external_serial_clock};
      sda_pipe <= {sda_pipe[1:0], external_serial_data};
    end
  end

  assign scl_sync   = scl_pipe[1];
  assign scl_hist   = scl_pipe[2];
  assign sda_sync   = sda_pipe[1];
  assign sda_hist   = sda_pipe[2];
  assign scl_rise   = scl_sync & ~scl_hist;
  assign scl_fall   = ~scl_sync & scl_hist;
  assign start_seen = scl_sync & scl_hist & sda_hist & ~sda_sync;
  assign stop_seen  = scl_sync & scl_hist & ~sda_hist & sda_sync;

  state_t                    state, state_n;
  logic [CW-1:0]             bit_count, bit_count_n;
  logic [SW-2:0]             shift_reg, shift_reg_n;
  logic [SW-1:0]             byte_in;
  logic [DATA_WIDTH-1:0]     tx_reg, tx_reg_n;
  logic                      sda_low, sda_low_n;
  logic                      ack_phase, ack_phase_n;
  logic                      rw, rw_n;
  logic                      pointer_set, pointer_set_n;
  logic                      nack, nack_n;
  logic                      read_load, read_load_n;
  logic [REGISTER_WIDTH-1:0] register_address_n;
  logic [DATA_WIDTH-1:0]     write_data_n;
  logic                      write_valid_n, read_request_n, busy_n;

  assign byte_in = {shift_reg, sda_sync};
  assign external_serial_data = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      bit_count        <= '0;
      shift_reg        <= '0;
      tx_reg           <= '0;
      sda_low          <= 1'b0;
      ack_phase        <= 1'b0;
      rw               <= 1'b0;
      pointer_set      <= 1'b0;
      nack             <= 1'b0;
      read_load        <= 1'b0;
      register_address <= '0;
      write_data       <= '0;
      write_valid      <= 1'b0;
      read_request     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      bit_count        <= bit_count_n;
      shift_reg        <= shift_reg_n;
      tx_reg           <= tx_reg_n;
      sda_low          <= sda_low_n;
      ack_phase        <= ack_phase_n;
      rw               <= rw_n;
      pointer_set      <= pointer_set_n;
      nack             <= nack_n;
      read_load        <= read_load_n;
      register_address <= register_address_n;
      write_data       <= write_data_n;
      write_valid      <= write_valid_n;
      read_request     <= read_request_n;
      busy             <= busy_n;
    end
  end

  always_comb begin
    state_n            = state;
    bit_count_n        = bit_count;
    shift_reg_n        = shift_reg;
    tx_reg_n           = tx_reg;
    sda_low_n          = sda_low;
    ack_phase_n        = ack_phase;
    rw_n               = rw;
    pointer_set_n      = pointer_set;
    nack_n             = nack;
    read_load_n        = 1'b0;
    register_address_n = register_address;
    write_data_n       = write_data;
    write_valid_n      = 1'b0;
    read_request_n     = 1'b0;
    busy_n             = busy;

    case (state)
      DEVICE_ADDRESS: begin
        if (scl_rise) begin
          shift_reg_n = byte_in[SW-2:0];
          bit_count_n = bit_count + CW'(1);
          if (bit_count == ADDR_LAST) begin
            bit_count_n = '0;
            ack_phase_n = 1'b0;
            if (byte_in[ADDRESS_WIDTH:1] == device_address) begin
              state_n = ADDRESS_ACK;
              rw_n    = byte_in[0];
              busy_n  = 1'b1;
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
      end
      ADDRESS_ACK, REGISTER_ACK, WRITE_ACK: begin
        // First falling edge starts the ACK bit, second one ends it.
        if (scl_fall) begin
          if (!ack_phase) begin
            sda_low_n   = 1'b1;
            ack_phase_n = 1'b1;
          end else begin
            sda_low_n   = 1'b0;
            ack_phase_n = 1'b0;
            bit_count_n = '0;
            if (state == WRITE_ACK) begin
              register_address_n = register_address + REGISTER_WIDTH'(1);
              state_n            = WRITE_DATA;
            end else if (state == REGISTER_ACK) begin
              state_n = WRITE_DATA;
            end else if (rw) begin
              state_n        = READ_DATA;
              read_request_n = 1'b1;
            end else if (pointer_set) begin
              state_n = WRITE_DATA;
            end else begin
              state_n = REGISTER_ADDRESS;
            end
          end
        end
      end
      REGISTER_ADDRESS: begin
        if (scl_rise) begin
          shift_reg_n = byte_in[SW-2:0];
          bit_count_n = bit_count + CW'(1);
          if (bit_count == REG_LAST) begin
            register_address_n = byte_in[REGISTER_WIDTH-1:0];
            pointer_set_n      = 1'b1;
            bit_count_n        = '0;
            state_n            = REGISTER_ACK;
          end
        end
      end
      WRITE_DATA: begin
        if (scl_rise) begin
          shift_reg_n = byte_in[SW-2:0];
          bit_count_n = bit_count + CW'(1);
          if (bit_count == DATA_LAST) begin
            write_data_n  = byte_in[DATA_WIDTH-1:0];
            write_valid_n = 1'b1;
            bit_count_n   = '0;
            state_n       = WRITE_ACK;
          end
        end
      end
      READ_DATA: begin
        // read_data is valid the cycle after read_request; MSB goes out then.
        read_load_n = read_request;
        if (read_load) begin
          tx_reg_n  = read_data;
          sda_low_n = ~read_data[DATA_WIDTH-1];
        end else if (scl_fall) begin
          if (bit_count == DATA_LAST) begin
            sda_low_n   = 1'b0;
            bit_count_n = '0;
            state_n     = READ_ACK;
          end else begin
            tx_reg_n    = tx_reg << 1;
            sda_low_n   = ~tx_reg[DATA_WIDTH-2];
            bit_count_n = bit_count + CW'(1);
          end
        end
      end
      READ_ACK: begin
        sda_low_n = 1'b0;
        if (scl_rise) begin
          nack_n = sda_sync;
        end
        if (scl_fall) begin
          if (nack) begin
            state_n = IGNORE;
            busy_n  = 1'b0;
          end else begin
            register_address_n = register_address + REGISTER_WIDTH'(1);
            read_request_n     = 1'b1;
            bit_count_n        = '0;
            state_n            = READ_DATA;
          end
        end
      end
      IGNORE: begin
        sda_low_n = 1'b0;
      end
      default: begin
        sda_low_n = 1'b0;
      end
    endcase

    // Bus conditions override whatever the byte logic decided this cycle.
    if (stop_seen) begin
      state_n        = IDLE;
      sda_low_n      = 1'b0;
      busy_n         = 1'b0;
      pointer_set_n  = 1'b0;
      ack_phase_n    = 1'b0;
      bit_count_n    = '0;
      write_valid_n  = 1'b0;
      read_request_n = 1'b0;
      read_load_n    = 1'b0;
    end else if (start_seen) begin
      state_n        = DEVICE_ADDRESS;
      sda_low_n      = 1'b0;
      ack_phase_n    = 1'b0;
      bit_count_n    = '0;
      write_valid_n  = 1'b0;
      read_request_n = 1'b0;
      read_load_n    = 1'b0;
      if (state == IDLE) begin
        pointer_set_n = 1'b0;
      end
    end
  end

endmodule
